fader_sched: RTL
================

FADER_SCHED -- requirements
Module: fader_sched

Interface
REQ-001 Parameter N, default 32, number of fader channels per frame.
REQ-002 Parameter PERIOD, default 512, clocks between fader start pulses; SHALL be >= 256+16.
REQ-003 Parameter DEPTH, default 64, output buffer entries; SHALL be a power of two and >= 2*N.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  level; 1 = schedule frames, 0 = finish current frame then idle.
REQ-007 load_t  in  1  pulse; loads t_init into time index (honoured only in IDLE).
REQ-008 t_init  in  25  initial time index.
REQ-009 f_start  out  1  single-cycle start pulse to fader.
REQ-010 f_t_index  out  25  time index to fader, stable from f_start until next f_start.
REQ-011 f_dv, f_chan[4:0], f_imag[15:0], f_real[15:0]  in  fader result strobe, channel, fade I/Q.
REQ-012 m_valid / m_ready  out / in  1 / 1  downstream handshake; transfer when both high.
REQ-013 m_data  out  32  {imag, real}; m_chan  out  5; m_last  out  1 (high when m_chan == 0).
REQ-014 frame_done  out  1  pulse when N-th result of a frame is received.
REQ-015 err_overrun, err_chan, err_drop  out  1 each  sticky error flags.
REQ-016 clr_err  in  1  pulse; clears all sticky errors.

Function
REQ-017 FSM states IDLE, WAIT, RUN; reset state IDLE.
REQ-018 IDLE -> WAIT when enable=1; period counter loaded with 0 so first start issues on the next WAIT cycle.
REQ-019 WAIT: when period counter is 0 and buffer free space >= N, assert f_start one cycle, reload counter to PERIOD-1, go RUN.
REQ-020 WAIT with counter 0 and free space < N: hold counter at 0, no start, t_index unchanged (stall).
REQ-021 Period counter decrements every cycle outside IDLE, saturating at 0.
REQ-022 RUN: count f_dv strobes; on N-th strobe pulse frame_done, increment f_t_index by 1 (mod 2^25), go WAIT if enable=1 else IDLE.
REQ-023 Counter reaching 0 while in RUN sets err_overrun; start deferred until RUN exits.
REQ-024 Expected channel for k-th strobe of a frame (k=0..N-1) is N-1-k; mismatch sets err_chan; data still buffered.
REQ-025 f_dv outside RUN is ignored for counting, sets err_chan, and is not buffered.
REQ-026 Each accepted strobe writes {f_imag, f_real, f_chan} to buffer; if buffer full, entry dropped and err_drop set.
REQ-027 Buffer is first-word-fall-through; m_valid rises 1 cycle after write into an empty buffer.
REQ-028 Simultaneous write and read on a full buffer: read completes, write accepted, no drop.
REQ-029 m_data/m_chan held stable while m_valid=1 and m_ready=0.
REQ-030 clr_err coincident with a new error event: flag ends set.
REQ-031 load_t outside IDLE ignored; t_index wraps 0x1FFFFFF -> 0.

Reset
REQ-032 reset_n=0: state IDLE, f_start=0, f_t_index=0, period counter 0, frame count 0, buffer empty, m_valid=0, frame_done=0, all err flags 0.
REQ-033 Reset mid-frame discards buffered and in-flight results; fader results arriving after reset release fall under REQ-025.

Structure
REQ-034 Package fader_sched_pack holds state enum, N, channel width (5), time width (25), buffer word type {16b imag, 16b real, 5b chan}.
REQ-035 One sub-module sync_fifo (parameterized width/depth, FWFT, full/empty/count outputs); FSM, counters, checks in fader_sched.

Verification
REQ-036 load_t with t_init=100, enable=1, model fader returns 32 ordered results per start -> f_start every 512 clocks, f_t_index 100,101,102; 32 outputs per frame, m_last on chan 0.
REQ-037 Hold m_ready=0 for 3 frames (96 entries > 64) -> third start stalled after 2 frames, no err_drop, resumes after draining.
REQ-038 Model fader delays frame completion past 512 clocks -> err_overrun=1, next start issues immediately after N-th result.
REQ-039 Inject chan 5 where 6 expected -> err_chan=1; clr_err -> 0.
REQ-040 Deassert enable mid-frame -> frame completes, FSM IDLE, no further f_start; spurious f_dv -> err_chan, not buffered.
REQ-041 Assert reset_n=0 mid-frame with 10 buffered -> m_valid=0, outputs at reset values, t_index 0.

Source files
------------

// File: rtl/fader_sched_pkg.sv
// Shared types and constants for the fader start scheduler and its result buffer.
package fader_sched_pack;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int N_CHAN = 32;
    localparam int CHAN_W = 5;
    localparam int TIME_W = 25;
    localparam int IQ_W   = 16;

    typedef struct packed {
        logic [IQ_W-1:0]   imag;
        logic [IQ_W-1:0]   re;
        logic [CHAN_W-1:0] chan;
    } buf_word_t;

    localparam int BUF_W = $bits(buf_word_t);

    // The fader reports channels in descending order: strobe k carries channel n-1-k.
    function automatic logic [CHAN_W-1:0] expected_chan(input int unsigned n, input int unsigned k);
        return CHAN_W'(n - 1 - k);
    endfunction

endpackage

// File: rtl/fader_sched_fifo.sv
// First-word-fall-through synchronous FIFO; read data is valid whenever o_empty is low.
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_rd;
    logic             w_do_wr;

    // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign w_do_rd = i_rd_en && !o_empty;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_do_wr && w_do_rd) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_count == (AW + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

endmodule

// File: rtl/fader_sched.sv
// Issues periodic fader start pulses, checks the returned channel sequence and
// buffers fade results for a downstream valid/ready consumer.
module fader_sched
    import fader_sched_pack::*;
#(
    parameter int N      = N_CHAN,
    parameter int PERIOD = 512,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              load_t,
    input  logic [24:0]       t_init,
    output logic              f_start,
    output logic [24:0]       f_t_index,
    input  logic              f_dv,
    input  logic [4:0]        f_chan,
    input  logic [15:0]       f_imag,
    input  logic [15:0]       f_real,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_data,
    output logic [4:0]        m_chan,
    output logic              m_last,
    output logic              frame_done,
    output logic              err_overrun,
    output logic              err_chan,
    output logic              err_drop,
    input  logic              clr_err,
    output logic [1:0]        o_dbg_state
);
    localparam int CNT_W = $clog2(PERIOD);
    localparam int K_W   = (N > 1) ? $clog2(N) : 1;
    localparam int FC_W  = $clog2(DEPTH) + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_period_cnt;
    logic [K_W-1:0]    r_k;
    logic [TIME_W-1:0] r_t_index;
    logic              r_frame_done;
    logic              r_err_overrun;
    logic              r_err_chan;
    logic              r_err_drop;

    logic              w_start;
    logic              w_strobe_ok;
    logic              w_last_strobe;
    logic              w_free_ok;
    logic              w_rd;
    logic              w_chan_evt;
    logic              w_overrun_evt;
    logic              w_drop_evt;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FC_W-1:0]   w_fifo_count;
    logic [CHAN_W-1:0] w_exp_chan;
    buf_word_t         w_wr_word;
    buf_word_t         w_rd_word;

    assign w_strobe_ok   = f_dv && (r_state == ST_RUN);
    assign w_exp_chan    = expected_chan(N, 32'(r_k));
    assign w_last_strobe = w_strobe_ok && (r_k == K_W'(N - 1));
    assign w_free_ok     = (w_fifo_count <= FC_W'(DEPTH - N));

    // Output handshake: m_valid is high whenever a result is buffered; a word
    // moves on every rising edge where m_valid and m_ready are both high, and
    // m_data/m_chan/m_last stay unchanged while m_valid is high and m_ready low.
    assign m_valid = !w_fifo_empty;
    assign w_rd    = m_valid && m_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if ((r_period_cnt == '0) && w_free_ok) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_strobe) begin
                    w_state_nxt = enable ? ST_WAIT : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The counter idles at zero, so leaving IDLE gives an immediate start and
    // a late frame releases the next start as soon as RUN exits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period_cnt <= '0;
            r_k          <= '0;
            r_t_index    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_period_cnt <= '0;
            end else if (w_start) begin
                r_period_cnt <= CNT_W'(PERIOD - 1);
            end else if (r_period_cnt != '0) begin
                r_period_cnt <= r_period_cnt - CNT_W'(1);
            end

            if (w_start || w_last_strobe) begin
                r_k <= '0;
            end else if (w_strobe_ok) begin
                r_k <= r_k + K_W'(1);
            end

            if ((r_state == ST_IDLE) && load_t) begin
                r_t_index <= t_init;
            end else if (w_last_strobe) begin
                r_t_index <= r_t_index + TIME_W'(1);
            end

            r_frame_done <= w_last_strobe;
        end
    end

    assign w_chan_evt    = (f_dv && (r_state != ST_RUN)) ||
                           (w_strobe_ok && (f_chan != w_exp_chan));
    assign w_overrun_evt = (r_state == ST_RUN) && (r_period_cnt == '0);
    assign w_drop_evt    = w_strobe_ok && w_fifo_full && !w_rd;

    // A new event in the same cycle as clr_err wins, so no error is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_overrun <= 1'b0;
            r_err_chan    <= 1'b0;
            r_err_drop    <= 1'b0;
        end else begin
            r_err_overrun <= (r_err_overrun && !clr_err) || w_overrun_evt;
            r_err_chan    <= (r_err_chan && !clr_err) || w_chan_evt;
            r_err_drop    <= (r_err_drop && !clr_err) || w_drop_evt;
        end
    end

    assign w_wr_word.imag = f_imag;
    assign w_wr_word.re   = f_real;
    assign w_wr_word.chan = f_chan;

    sync_fifo #(
        .WIDTH (BUF_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (w_strobe_ok),
        .i_wr_data (w_wr_word),
        .i_rd_en   (w_rd),
        .o_rd_data (w_rd_word),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign f_start     = w_start;
    assign f_t_index   = r_t_index;
    assign m_data      = {w_rd_word.imag, w_rd_word.re};
    assign m_chan      = w_rd_word.chan;
    assign m_last      = (w_rd_word.chan == '0);
    assign frame_done  = r_frame_done;
    assign err_overrun = r_err_overrun;
    assign err_chan    = r_err_chan;
    assign err_drop    = r_err_drop;
    assign o_dbg_state = r_state;

endmodule
